// File: rtl/map_ss_pkg.sv
// rtl/map_ss_pkg.sv - shared state encoding and defaults for the save-state sequencer
package map_ss_pkg;

    typedef enum logic [2:0] {
        IDLE,
        S_SET,
        S_MEM,
        L_IDX_MEM,
        L_IDX_CMP,
        L_MEM,
        L_WE,
        FIN
    } ss_state_e;

    localparam int SS_IDX_ADDR    = 127;
    localparam int DEF_REG_CNT    = 10;
    localparam int DEF_SETTLE     = 2;
    localparam int DEF_WE_CYC     = 4;

endpackage

// File: rtl/ss_tmr.sv
// rtl/ss_tmr.sv - loadable 4-bit down-counter with zero flag for settle/strobe waits
module ss_tmr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Load has priority over decrement; the count parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/map_ss_seq.sv
// rtl/map_ss_seq.sv - mapper save-state sequencer: snapshot save and index-checked restore
module map_ss_seq
    import map_ss_pkg::*;
#(
    parameter int REG_CNT  = DEF_REG_CNT,
    parameter int IDX_ADDR = SS_IDX_ADDR,
    parameter int SETTLE   = DEF_SETTLE,
    parameter int WE_CYC   = DEF_WE_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       save_go,
    input  logic       load_go,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdat,
    input  logic [7:0] mem_rdat,
    input  logic       mem_ack
);

    localparam logic [6:0] LAST_REG = 7'(REG_CNT - 1);
    localparam logic [6:0] IDX_SLOT = 7'(REG_CNT);
    localparam logic [7:0] IDX_A8   = 8'(IDX_ADDR);
    localparam logic [3:0] SETTLE_L = 4'(SETTLE);
    localparam logic [3:0] WE_L     = 4'(WE_CYC);

    ss_state_e  state_q, state_d;
    logic [6:0] idx_q, idx_d;
    logic [7:0] cmp_q, cmp_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       ss_act_q, ss_act_d;
    logic       ss_we_q, ss_we_d;
    logic [7:0] ss_addr_q, ss_addr_d;
    logic [7:0] ss_wdat_q, ss_wdat_d;
    logic       mem_req_q, mem_req_d;
    logic       mem_we_q, mem_we_d;
    logic [7:0] mem_wdat_q, mem_wdat_d;

    logic       tmr_load;
    logic [3:0] tmr_val;
    logic       tmr_dec;
    logic       tmr_zero;

    ss_tmr u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Next state, address sequencing and datapath; all outputs are registered
    // from the next state so ss_act/busy track the state and done trails FIN.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cmp_d      = cmp_q;
        err_d      = err_q;
        ss_we_d    = 1'b0;
        ss_addr_d  = ss_addr_q;
        ss_wdat_d  = ss_wdat_q;
        mem_wdat_d = mem_wdat_q;
        tmr_load   = 1'b0;
        tmr_val    = SETTLE_L;
        tmr_dec    = 1'b0;
        case (state_q)
            IDLE: begin
                if (save_go) begin
                    state_d   = S_SET;
                    idx_d     = 7'd0;
                    err_d     = 1'b0;
                    ss_addr_d = 8'd0;
                    tmr_load  = 1'b1;
                end else if (load_go) begin
                    state_d   = L_IDX_MEM;
                    err_d     = 1'b0;
                    ss_addr_d = IDX_A8;
                end
            end
            S_SET: begin
                if (tmr_zero) begin
                    mem_wdat_d = ss_rdat;
                    state_d    = S_MEM;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (idx_q == IDX_SLOT) begin
                        state_d = FIN;
                    end else begin
                        idx_d     = idx_q + 7'd1;
                        ss_addr_d = (idx_q == LAST_REG) ? IDX_A8 : {1'b0, idx_q + 7'd1};
                        tmr_load  = 1'b1;
                        state_d   = S_SET;
                    end
                end
            end
            L_IDX_MEM: begin
                if (mem_ack) begin
                    cmp_d    = mem_rdat;
                    tmr_load = 1'b1;
                    state_d  = L_IDX_CMP;
                end
            end
            L_IDX_CMP: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (cmp_q != ss_rdat) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    idx_d     = 7'd0;
                    ss_addr_d = 8'd0;
                    state_d   = L_MEM;
                end
            end
            L_MEM: begin
                if (mem_ack) begin
                    ss_wdat_d = mem_rdat;
                    tmr_load  = 1'b1;
                    tmr_val   = WE_L;
                    state_d   = L_WE;
                end
            end
            L_WE: begin
                // setup cycle (we low, count WE_CYC), WE_CYC strobe cycles, hold cycle
                if (!tmr_zero) begin
                    ss_we_d = 1'b1;
                    tmr_dec = 1'b1;
                end else if (!ss_we_q) begin
                    if (idx_q == LAST_REG) begin
                        state_d = FIN;
                    end else begin
                        idx_d     = idx_q + 7'd1;
                        ss_addr_d = {1'b0, idx_q + 7'd1};
                        state_d   = L_MEM;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d    = (state_q == FIN);
        ss_act_d  = (state_d != IDLE);
        mem_req_d = (state_d == S_MEM) || (state_d == L_IDX_MEM) || (state_d == L_MEM);
        mem_we_d  = (state_d == S_MEM);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 7'd0;
            cmp_q      <= 8'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ss_act_q   <= 1'b0;
            ss_we_q    <= 1'b0;
            ss_addr_q  <= 8'd0;
            ss_wdat_q  <= 8'd0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_wdat_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cmp_q      <= cmp_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ss_act_q   <= ss_act_d;
            ss_we_q    <= ss_we_d;
            ss_addr_q  <= ss_addr_d;
            ss_wdat_q  <= ss_wdat_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_wdat_q <= mem_wdat_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign ss_act   = ss_act_q;
    assign ss_we    = ss_we_q;
    assign ss_addr  = ss_addr_q;
    assign ss_wdat  = ss_wdat_q;
    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = ss_addr_q;
    assign mem_wdat = mem_wdat_q;

endmodule

// File: doc/map_ss_seq.md
Name: map_ss_seq

Overview:
- Save-state sequencer for mapper register files that expose the ss_act/ss_we/ss_addr/ss_rdat snapshot port. Typical client: a 6×CHR, 3×PRG plus flag-byte mapper, with map_idx at ss_addr 127.
- On a save command it walks ss_addr 0..REG_CNT-1, then IDX_ADDR, and copies each ss_rdat byte into snapshot memory through a req/ack port.
- On a load command it checks the stored map_idx against the live mapper. If they match, it streams the stored bytes back through ss_we.
- Sits between the menu/OS command logic and the mapper.

Parameters:
- REG_CNT, 10, number of register bytes at ss_addr 0..REG_CNT-1 (1..126).
- IDX_ADDR, 127, ss_addr of the mapper index byte.
- SETTLE, 2, clk cycles ss_addr is held before ss_rdat is sampled (1..15).
- WE_CYC, 4, clk cycles ss_we is held per byte so the mapper's m2-edge capture sees it (1..15).

Ports:
- clk in 1: system clock.
- rst_n in 1: asynchronous active-low reset.
- save_go in 1: one-cycle save request, honoured only in IDLE.
- load_go in 1: one-cycle load request, honoured only in IDLE.
- busy out 1: high whenever state is not IDLE.
- done out 1: one-cycle pulse when a sequence finishes, whether ok or error.
- err out 1: sticky; set on map_idx mismatch; cleared on the next accepted go.
- ss_act out 1: save-state mode enable to the mapper.
- ss_we out 1: register write strobe to the mapper.
- ss_addr out 8: mapper register select.
- ss_wdat out 8: write data to the mapper (muxed onto cpu_dat upstream).
- ss_rdat in 8: mapper readback.
- mem_req out 1: memory request; held until mem_ack.
- mem_we out 1: 1 = write, 0 = read; valid with mem_req.
- mem_addr out 8: snapshot byte offset (equals ss_addr).
- mem_wdat out 8: write data.
- mem_rdat in 8: read data; valid in the mem_ack cycle.
- mem_ack in 1: one-cycle completion.

Behaviour:
- Reset values: busy, done, err, ss_act, ss_we, mem_req and mem_we are 0. ss_addr, ss_wdat, mem_addr and mem_wdat are 0. State is IDLE. Reset mid-sequence drops ss_act and mem_req immediately and does not resume.
- States: IDLE, S_SET, S_MEM, L_IDX_MEM, L_IDX_CMP, L_MEM, L_WE, FIN.
- IDLE:
  - save_go → S_SET with idx=0 and err=0.
  - load_go (and no save_go) → L_IDX_MEM with err=0.
  - save_go and load_go in the same cycle: save wins.
  - go pulses while busy are ignored.
- Address sequence: 0,1,..,REG_CNT-1, IDX_ADDR.
- ss_act=1 from the first cycle after acceptance through FIN; it falls in the same cycle as done.
- Save path:
  - S_SET: drive ss_addr=seq[idx]; count SETTLE cycles; then latch ss_rdat into mem_wdat → S_MEM.
  - S_MEM: mem_req=1, mem_we=1, mem_addr=ss_addr; hold until mem_ack.
  - On ack: if the last element (IDX_ADDR) was written → FIN; else idx+1 → S_SET.
- Load path:
  - L_IDX_MEM: mem read at IDX_ADDR while ss_addr=IDX_ADDR. On ack, latch mem_rdat → L_IDX_CMP.
  - L_IDX_CMP: wait SETTLE cycles, then compare with ss_rdat. Mismatch → err=1, → FIN with no ss_we ever asserted. Match → idx=0, → L_MEM.
  - L_MEM: mem read at addr idx, ss_addr=idx. On ack, ss_wdat=mem_rdat → L_WE.
  - L_WE: ss_we=1 for exactly WE_CYC cycles with ss_addr/ss_wdat stable. They are also stable 1 cycle before ss_we rises and 1 cycle after it falls.
  - After L_WE: if idx=REG_CNT-1 → FIN; else idx+1 → L_MEM. IDX_ADDR is never written.
- FIN: done=1 for one cycle, ss_act=0, mem_req=0 → IDLE.
- No request is abandoned: mem_req stays high with stable addr/we/wdat until ack. There is no timeout.
- mem_ack while mem_req=0 is ignored.
- Counters: idx is 7-bit; the settle and we counters are 4-bit and reload per byte.
- Latency, save, zero-wait memory: (REG_CNT+1)·(SETTLE+2)+2 cycles from go to done.

Decomposition:
- Shared package (map_ss_pkg):
  - state encoding;
  - SS_IDX_ADDR=127 constant;
  - default REG_CNT/SETTLE/WE_CYC.
- One natural sub-module, ss_tmr: loadable 4-bit down-counter with zero flag, used for both the SETTLE and WE_CYC waits.
- FSM, address sequencing and datapath stay in map_ss_seq.

Test Plan:
- Save, default params, model mapper regs = 0x10..0x19 and map_idx=0x52, memory acks after 1 cycle → mem writes to addrs 0..9 with data 0x10..0x19, then addr 127 with data 0x52; done 1 pulse; err=0.
- Load match: memory[127]=0x52, memory[0..9]=0xA0..0xA9, mapper map_idx=0x52 → exactly 10 ss_we pulses, each 4 cycles, ss_addr 0..9 with ss_wdat 0xA0..0xA9; no write to 127; done; err=0.
- Load mismatch: memory[127]=0x04, mapper 0x52 → ss_we never asserts, err=1, one done pulse. A following valid save_go clears err.
- Memory stall: mem_ack delayed 7 cycles on byte 3 of a save → mem_req, mem_addr=3 and mem_wdat held stable for all 7 cycles; sequence continues unchanged.
- Simultaneous save_go and load_go in IDLE → save sequence runs. load_go pulsed mid-save → ignored; busy stays 1.
- rst_n asserted during L_WE of byte 5 → ss_we, ss_act, mem_req and busy drop asynchronously; after release, state is IDLE and done stays 0.
